// File: rtl/mc_pkg.sv
// ============================================================================
// Module      : mc_pkg
// Description : Shared types and encodings for the multicycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXECR  = 4'd2,
    S_EXECI  = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP      = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BR      = 2'b10;

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module      : multicycle_controller_if
// Description : Instruction-field inputs and datapath controls of the core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_controller_if;

  logic [1:0] Op;
  logic [2:0] Funct;
  logic [3:0] Rd;
  logic       CondEx;

  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic       PCWrite;
  logic       RegW;
  logic       MemW;
  logic [1:0] FlagW;
  logic       Illegal;
  logic       InstrDone;

  // Controller side
  modport master (
    input  Op, Funct, Rd, CondEx,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc,
           ImmSrc, RegSrc, PCWrite, RegW, MemW, FlagW, Illegal, InstrDone
  );

  // Datapath side
  modport slave (
    output Op, Funct, Rd, CondEx,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc,
           ImmSrc, RegSrc, PCWrite, RegW, MemW, FlagW, Illegal, InstrDone
  );

endinterface

`default_nettype wire

// File: rtl/mc_alu_decoder.sv
// ============================================================================
// Module      : mc_alu_decoder
// Description : DP command to ALU operation and flag-write enables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_alu_decoder (
  input  wire logic       alu_op,
  input  wire logic [1:0] cmd,
  input  wire logic       cond_ex_r,
  output logic      [1:0] alu_control,
  output logic      [1:0] flag_w
);

  always_comb begin
    alu_control = 2'b00;
    flag_w      = 2'b00;
    if (alu_op) begin
      case (cmd)
        2'b00: alu_control = 2'b00;
        2'b01: alu_control = 2'b01;
        2'b10: begin
          alu_control = 2'b01;
          flag_w      = {2{cond_ex_r}};
        end
        // Unimplemented command performs no writes, flags included
        default: alu_control = 2'b00;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module      : multicycle_controller
// Description : Multicycle control FSM sequencing ALU, memory, IR and regfile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
  import mc_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH,
  parameter int     PC_INC      = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  multicycle_controller_if.master bus
);

  if (PC_INC != 4) begin : g_pc_inc_check
    $error("multicycle_controller: datapath constant operand must be 4");
  end

  state_t     state_d, state_q;
  logic       cond_ex_r_d, cond_ex_r_q;
  logic       alu_op;
  logic [1:0] alu_control;
  logic [1:0] flag_w;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic       rd_is_pc;

  mc_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .cmd         (bus.Funct[1:0]),
    .cond_ex_r   (cond_ex_r_q),
    .alu_control (alu_control),
    .flag_w      (flag_w)
  );

  assign alu_op   = (state_q == S_EXECR) || (state_q == S_EXECI);
  assign rd_is_pc = (bus.Rd == 4'b1111);

  always_comb begin
    imm_src = 2'b00;
    reg_src = 2'b00;
    case (bus.Op)
      OP_MEM: begin
        imm_src = 2'b01;
        reg_src = bus.Funct[2] ? 2'b00 : 2'b10;
      end
      OP_BR: begin
        imm_src = 2'b10;
        reg_src = 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cond_ex_r_d    = cond_ex_r_q;
    bus.IRWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = SRCB_RD2;
    bus.ALUControl = alu_control;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ImmSrc     = (state_q == S_FETCH) ? 2'b00 : imm_src;
    bus.RegSrc     = (state_q == S_FETCH) ? 2'b00 : reg_src;
    bus.PCWrite    = 1'b0;
    bus.RegW       = 1'b0;
    bus.MemW       = 1'b0;
    bus.FlagW      = flag_w;
    bus.Illegal    = 1'b0;
    bus.InstrDone  = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
        bus.PCWrite   = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        cond_ex_r_d = bus.CondEx;
        case (bus.Op)
          OP_DP:   state_d = bus.Funct[2] ? S_EXECI : S_EXECR;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: begin
            bus.Illegal   = 1'b1;
            bus.InstrDone = 1'b1;
            state_d       = S_FETCH;
          end
        endcase
      end
      S_EXECR, S_EXECI: begin
        bus.ALUSrcB = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RD2;
        case (bus.Funct[1:0])
          2'b10: begin
            bus.InstrDone = 1'b1;
            state_d       = S_FETCH;
          end
          2'b11: begin
            bus.Illegal   = 1'b1;
            bus.InstrDone = 1'b1;
            state_d       = S_FETCH;
          end
          default: state_d = S_ALUWB;
        endcase
      end
      S_ALUWB, S_MEMWB: begin
        bus.ResultSrc = (state_q == S_MEMWB) ? RES_DATA : RES_ALUOUT;
        bus.RegW      = cond_ex_r_q & ~rd_is_pc;
        bus.PCWrite   = cond_ex_r_q & rd_is_pc;
        bus.InstrDone = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMADR: begin
        bus.ALUSrcB = SRCB_IMM;
        state_d     = bus.Funct[2] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.AdrSrc = 1'b1;
        state_d    = S_MEMWB;
      end
      S_MEMWR: begin
        bus.AdrSrc    = 1'b1;
        bus.MemW      = cond_ex_r_q;
        bus.InstrDone = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALU;
        bus.PCWrite   = cond_ex_r_q;
        bus.InstrDone = 1'b1;
        state_d       = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Synchronous reset still blanks every control in the cycle it is high
    if (reset) begin
      bus.IRWrite    = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.ALUSrcA    = 1'b0;
      bus.ALUSrcB    = 2'b00;
      bus.ALUControl = 2'b00;
      bus.ResultSrc  = 2'b00;
      bus.ImmSrc     = 2'b00;
      bus.RegSrc     = 2'b00;
      bus.PCWrite    = 1'b0;
      bus.RegW       = 1'b0;
      bus.MemW       = 1'b0;
      bus.FlagW      = 2'b00;
      bus.Illegal    = 1'b0;
      bus.InstrDone  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      cond_ex_r_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cond_ex_r_q <= cond_ex_r_d;
    end
  end

endmodule

`default_nettype wire
